// File: rtl/seq_pkg.sv
// seq_pkg.sv -- shared state/pc-control types and defaults for seq_ctrl.
// Imported by seq_pc and seq_ctrl.
package seq_pkg;

    localparam int PC_W_DEF    = 10;
    localparam int TMO_CYC_DEF = 15;
    localparam int IR_W        = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    typedef enum logic [1:0] {
        PC_HOLD,
        PC_INC,
        PC_LOAD,
        PC_CLR
    } pc_op_t;

endpackage

// File: rtl/seq_pc.sv
// seq_pc.sv -- program counter register for seq_ctrl.
// Supports hold, increment (wrapping), load and clear.
module seq_pc
    import seq_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  pc_op_t          op,
    input  logic [PC_W-1:0] d,
    output logic [PC_W-1:0] pc
);

    localparam logic [PC_W-1:0] ONE = {{(PC_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else begin
            unique case (op)
                PC_INC:  pc <= pc + ONE;
                PC_LOAD: pc <= d;
                PC_CLR:  pc <= '0;
                default: pc <= pc;
            endcase
        end
    end

endmodule

// File: rtl/seq_ctrl.sv
// seq_ctrl.sv -- fetch/decode/exec/mem/wb sequencer with imem/dmem handshakes.
// Define SEQ_TIMEOUT_EN to enable the data-memory ack watchdog.
module seq_ctrl
    import seq_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int TMO_CYC = TMO_CYC_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [PC_W-1:0] end_pc,
    output logic            imem_req,
    input  logic            imem_ack,
    output logic [PC_W-1:0] imem_addr,
    input  logic [IR_W-1:0] instr,
    input  logic            is_put,
    input  logic            is_jump,
    input  logic            is_cbr,
    input  logic            is_load,
    input  logic            is_store,
    input  logic            reg_wr,
    input  logic            alu_cond,
    input  logic [PC_W-1:0] br_target,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    output logic [IR_W-1:0] ir,
    output logic            put_we,
    output logic            alu_en,
    output logic            reg_we,
    output logic [PC_W-1:0] pc,
    output logic            done,
    output logic            err
);

    state_t st, nxt;
    pc_op_t pc_op;
    logic   mem_st;
    logic   tmo_hit;
    logic   idle_like;

    assign idle_like = (st == S_IDLE) || (st == S_HALT);

    seq_pc #(
        .PC_W(PC_W)
    ) u_pc (
        .clk  (clk),
        .rst_n(rst_n),
        .op   (pc_op),
        .d    (br_target),
        .pc   (pc)
    );

    assign imem_addr = pc;
    assign done      = (st == S_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= S_IDLE;
        end else begin
            st <= nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir <= '0;
        end else if (imem_req && imem_ack) begin
            ir <= instr;
        end
    end

    // Latch the access direction so dmem_we stays stable for the whole MEM stay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_st <= 1'b0;
        end else if (st == S_EXEC) begin
            mem_st <= is_store;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam logic [TW-1:0] TLIM = TW'(TMO_CYC - 1);
    localparam logic [TW-1:0] TONE = TW'(1);

    logic [TW-1:0] tcnt;
    logic          err_q;

    assign tmo_hit = (tcnt == TLIM);
    assign err     = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt  <= '0;
            err_q <= 1'b0;
        end else begin
            if (st == S_EXEC) begin
                tcnt <= '0;
            end else if (st == S_MEM) begin
                tcnt <= tcnt + TONE;
            end
            if (idle_like && start) begin
                err_q <= 1'b0;
            end else if (st == S_MEM && !dmem_ack && tmo_hit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        nxt      = st;
        pc_op    = PC_HOLD;
        imem_req = 1'b0;
        put_we   = 1'b0;
        alu_en   = 1'b0;
        reg_we   = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        unique case (st)
            S_IDLE, S_HALT: begin
                if (start) begin
                    nxt   = S_FETCH;
                    pc_op = PC_CLR;
                end
            end
            S_FETCH: begin
                if (pc == end_pc) begin
                    nxt = S_HALT;
                end else begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        nxt = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                if (is_put) begin
                    put_we = 1'b1;
                    pc_op  = PC_INC;
                    nxt    = S_FETCH;
                end else begin
                    nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_en = 1'b1;
                priority case (1'b1)
                    is_jump: begin
                        pc_op = PC_LOAD;
                        nxt   = S_FETCH;
                    end
                    is_cbr: begin
                        pc_op = alu_cond ? PC_LOAD : PC_INC;
                        nxt   = S_FETCH;
                    end
                    is_load, is_store: begin
                        nxt = S_MEM;
                    end
                    default: begin
                        nxt = S_WB;
                    end
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = mem_st;
                if (dmem_ack) begin
                    if (mem_st) begin
                        pc_op = PC_INC;
                        nxt   = S_FETCH;
                    end else begin
                        nxt = S_WB;
                    end
                end else if (tmo_hit) begin
                    nxt = S_HALT;
                end
            end
            S_WB: begin
                reg_we = reg_wr;
                pc_op  = PC_INC;
                nxt    = S_FETCH;
            end
            default: begin
                nxt = S_IDLE;
            end
        endcase
    end

endmodule
